reverse_mix_cols: RTL and testbench
===================================

Name:
reverse_mix_cols

Overview:
- Registered AES InvMixColumns on one 32-bit state column; used in the AES decryption datapath after InvShiftRows/InvSubBytes and AddRoundKey.
- Takes a column qualified by in_valid and returns the GF(2^8) inverse-mixed column one clock later, qualified by out_valid.
- Fully pipelined: accepts one column every cycle.

Parameters:
- None. Width is fixed at 32 bits, four bytes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input_col holds a valid column this cycle.
- input_col  input  32  column bytes a0..a3; a0 = bits [31:24] (row 0), a3 = bits [7:0] (row 3).
- out_valid  output  1  final_col is valid this cycle.
- final_col  output  32  result bytes b0..b3, same byte ordering as input_col.

Behaviour:
- Arithmetic is in GF(2^8) with reduction polynomial x^8+x^4+x^3+x+1 (0x11B). Addition is XOR.
- xtime(v) = (v<<1)[7:0] XOR (0x1B if v[7] is 1).
- Multiplies are built from xtime:
  - x9 = x8^x1
  - xB = x8^x2^x1
  - xD = x8^x4^x1
  - xE = x8^x4^x2
- Output bytes:
  - b0 = E·a0 ^ B·a1 ^ D·a2 ^ 9·a3
  - b1 = 9·a0 ^ E·a1 ^ B·a2 ^ D·a3
  - b2 = D·a0 ^ 9·a1 ^ E·a2 ^ B·a3
  - b3 = B·a0 ^ D·a1 ^ 9·a2 ^ E·a3
- Math is purely combinational from input_col. The result is registered on the rising edge of clk.
- Latency is exactly 1 cycle: in_valid=1 at edge N gives out_valid=1 and the result on final_col after edge N, held until edge N+1.
- The output register loads only when in_valid=1. When in_valid=0, final_col holds its last value and out_valid goes to 0 at the next edge.
- No backpressure; no ready signal exists.
- Back-to-back valids produce back-to-back results with no bubbles.
- Reset: rst_n low immediately (asynchronously) forces out_valid=0 and final_col=32'h0. Reset asserted mid-stream discards the in-flight result.
- After reset release, the first capture occurs at the first rising edge with in_valid=1.
- X on input_col while in_valid=0 must not propagate to final_col.

Optional Feature:
- Macro RMC_FWD_MODE_EN.
- When defined:
  - Adds input port fwd (1 bit), placed after in_valid.
  - fwd=1 sampled with in_valid computes forward MixColumns: b0=2a0^3a1^a2^a3, rotated per row likewise.
  - fwd=0 computes the inverse transform.
- When not defined: no fwd port, inverse transform only, and no added logic.

Decomposition:
- Shared package aes_gf_pkg:
  - function xtime
  - constants for reduction 8'h1B and the coefficients 8'h09, 8'h0B, 8'h0D, 8'h0E (and 8'h02, 8'h03 for forward mode)
  - typedef byte_t (8-bit logic)
- One natural sub-module, inv_mix_byte: combinational, takes four bytes, produces one output byte. It is instantiated four times with rotated byte order.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> out_valid=0 and final_col=00000000 immediately, without waiting for a clock edge.
- input_col=416e1899, in_valid=1 -> next cycle final_col=c9dad76a, out_valid=1.
- input_col=e0958b65 on the cycle directly after 416e1899 (back-to-back) -> results c9dad76a then 926bd4b6 on consecutive cycles, out_valid high for both.
- input_col=01000000 -> 0e090d0b; input_col=ffffffff -> ffffffff; input_col=00000000 -> 00000000.
- in_valid=0 with input_col changing after a result -> final_col holds its previous value and out_valid=0.
- With RMC_FWD_MODE_EN: fwd=1, input_col=c9dad76a -> 416e1899; fwd=0, input_col=416e1899 -> c9dad76a.

Source files
------------

// File: rtl/aes_gf_pkg.sv
// GF(2^8) helpers shared by the AES column-mixing datapath.
// Reduction polynomial x^8+x^4+x^3+x+1; constant multiplies are built from xtime.
package aes_gf_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t GF_POLY = 8'h1B;

    localparam byte_t C_02 = 8'h02;
    localparam byte_t C_03 = 8'h03;
    localparam byte_t C_09 = 8'h09;
    localparam byte_t C_0B = 8'h0B;
    localparam byte_t C_0D = 8'h0D;
    localparam byte_t C_0E = 8'h0E;

    function automatic byte_t xtime(input byte_t v);
        return {v[6:0], 1'b0} ^ (v[7] ? GF_POLY : 8'h00);
    endfunction

    // Multiply by a coefficient whose set bits select the 1/2/4/8 partial products.
    function automatic byte_t gf_mul(input byte_t v, input logic [3:0] c);
        byte_t x2;
        byte_t x4;
        byte_t x8;
        x2 = xtime(v);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? v  : 8'h00) ^
               (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^
               (c[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_byte.sv
// One output byte of (Inv)MixColumns: E*a0 ^ B*a1 ^ D*a2 ^ 9*a3.
// With RMC_FWD_MODE_EN, fwd=1 selects the forward row 2*a0 ^ 3*a1 ^ a2 ^ a3.
module inv_mix_byte
    import aes_gf_pkg::*;
(
`ifdef RMC_FWD_MODE_EN
    input  logic  fwd,
`endif
    input  byte_t a0,
    input  byte_t a1,
    input  byte_t a2,
    input  byte_t a3,
    output byte_t b
);

    byte_t inv_b;

    always_comb begin
        inv_b = gf_mul(a0, C_0E[3:0]) ^ gf_mul(a1, C_0B[3:0]) ^
                gf_mul(a2, C_0D[3:0]) ^ gf_mul(a3, C_09[3:0]);
    end

`ifdef RMC_FWD_MODE_EN
    byte_t fwd_b;

    always_comb begin
        fwd_b = gf_mul(a0, C_02[3:0]) ^ gf_mul(a1, C_03[3:0]) ^ a2 ^ a3;
        b     = fwd ? fwd_b : inv_b;
    end
`else
    always_comb begin
        b = inv_b;
    end
`endif

endmodule

// File: rtl/reverse_mix_cols.sv
// Registered AES InvMixColumns on one 32-bit column, one-cycle latency, fully pipelined.
// Optional macro RMC_FWD_MODE_EN adds a fwd input selecting forward MixColumns.
module reverse_mix_cols
    import aes_gf_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
`ifdef RMC_FWD_MODE_EN
    input  logic        fwd,
`endif
    input  logic [31:0] input_col,
    output logic        out_valid,
    output logic [31:0] final_col
);

    byte_t a0, a1, a2, a3;
    byte_t b0, b1, b2, b3;

    always_comb begin
        a0 = input_col[31:24];
        a1 = input_col[23:16];
        a2 = input_col[15:8];
        a3 = input_col[7:0];
    end

    // Each row is the same byte function applied to the column rotated by the row index.
    inv_mix_byte u_row0 (
`ifdef RMC_FWD_MODE_EN
        .fwd (fwd),
`endif
        .a0  (a0), .a1 (a1), .a2 (a2), .a3 (a3), .b (b0)
    );

    inv_mix_byte u_row1 (
`ifdef RMC_FWD_MODE_EN
        .fwd (fwd),
`endif
        .a0  (a1), .a1 (a2), .a2 (a3), .a3 (a0), .b (b1)
    );

    inv_mix_byte u_row2 (
`ifdef RMC_FWD_MODE_EN
        .fwd (fwd),
`endif
        .a0  (a2), .a1 (a3), .a2 (a0), .a3 (a1), .b (b2)
    );

    inv_mix_byte u_row3 (
`ifdef RMC_FWD_MODE_EN
        .fwd (fwd),
`endif
        .a0  (a3), .a1 (a0), .a2 (a1), .a3 (a2), .b (b3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            final_col <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                final_col <= {b0, b1, b2, b3};
            end
        end
    end

endmodule

// File: tb/tb_reverse_mix_cols.sv
// Scoreboard bench for reverse_mix_cols: stimulus pushes expected columns, a monitor pops them.
// Forward-mode vectors are exercised when RMC_FWD_MODE_EN is defined.
module tb_reverse_mix_cols;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] input_col;
    logic        out_valid;
    logic [31:0] final_col;
`ifdef RMC_FWD_MODE_EN
    logic        fwd;
`endif

    logic [31:0] exp_q[$];
    int          checks;
    int          failures;

    reverse_mix_cols dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
`ifdef RMC_FWD_MODE_EN
        .fwd       (fwd),
`endif
        .input_col (input_col),
        .out_valid (out_valid),
        .final_col (final_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one cycle of input just after a rising edge; it is captured on the next edge.
    task automatic drive(input logic v, input logic [31:0] col, input logic [31:0] exp);
        @(posedge clk);
        #1;
        in_valid  = v;
        input_col = col;
`ifdef RMC_FWD_MODE_EN
        fwd       = 1'b0;
`endif
        if (v) exp_q.push_back(exp);
    endtask

`ifdef RMC_FWD_MODE_EN
    task automatic drive_fwd(input logic f, input logic [31:0] col, input logic [31:0] exp);
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        fwd       = f;
        input_col = col;
        exp_q.push_back(exp);
    endtask
`endif

    // Monitor: every presented result must match the oldest outstanding expectation.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got %08h expected no output", final_col);
                end else begin
                    e = exp_q.pop_front();
                    check("result", final_col, e);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        input_col = 32'h0;
`ifdef RMC_FWD_MODE_EN
        fwd       = 1'b0;
`endif
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_col", final_col, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back pair, then idle with X on the column.
        drive(1'b1, 32'h416e1899, 32'hc9dad76a);
        drive(1'b1, 32'he0958b65, 32'h926bd4b6);
        check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b0, 32'hxxxxxxxx, 32'h0);
        check("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_second_col", final_col, 32'h926bd4b6);
        drive(1'b0, 32'h12345678, 32'h0);
        check("idle_valid", {31'd0, out_valid}, 32'd0);
        check("idle_hold_x", final_col, 32'h926bd4b6);

        drive(1'b1, 32'h01000000, 32'h0e090d0b);
        drive(1'b1, 32'hffffffff, 32'hffffffff);
        drive(1'b1, 32'h00000000, 32'h00000000);
        drive(1'b1, 32'h416e1899, 32'hc9dad76a);
        drive(1'b0, 32'hdeadbeef, 32'h0);
        drive(1'b0, 32'h01000000, 32'h0);
        check("hold_valid", {31'd0, out_valid}, 32'd0);
        check("hold_col", final_col, 32'hc9dad76a);

        // Asynchronous reset with a fresh result on the output.
        drive(1'b1, 32'he0958b65, 32'h926bd4b6);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_col", final_col, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef RMC_FWD_MODE_EN
        drive_fwd(1'b1, 32'hc9dad76a, 32'h416e1899);
        drive_fwd(1'b0, 32'h416e1899, 32'hc9dad76a);
        drive_fwd(1'b1, 32'h01000000, 32'h02010103);
`endif
        drive(1'b1, 32'h01000000, 32'h0e090d0b);
        drive(1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain_outstanding", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
